wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback stage directly upstream of the integer register file. Merges two result
//  sources onto the single RF write port: the ALU, which is single-cycle and never
//  back-pressured, and the LSU/MUL-DIV, which is variable-latency and valid/ready.
//  LSU results queue in a small FIFO. The FIFO drains when the ALU is idle, and a
//  starvation guard forces a drain when the ALU keeps it blocked.
//  Exports a pending-rd mask so issue logic can block RAW/WAW on queued writes.
// PARAMETERS
//  XLEN        32  data width (from tcore_param)
//  DEPTH       4   LSU result FIFO entries; must be a power of 2 and >= 2
//  STARVE_MAX  8   consecutive blocked cycles before stall_o pulses; must be >= 2
// PORTS
//  clk_i         in   1              clock, rising edge
//  rst_i         in   1              synchronous reset, active high
//  alu_valid_i   in   1              ALU result valid this cycle
//  alu_rd_i      in   5              ALU destination register
//  alu_data_i    in   XLEN           ALU result
//  lsu_valid_i   in   1              LSU result valid
//  lsu_ready_o   out  1              FIFO can accept an LSU result
//  lsu_rd_i      in   5              LSU destination register
//  lsu_data_i    in   XLEN           LSU result
//  stall_o       out  1              registered; upstream must hold alu_valid_i=0 this cycle
//  rf_we_o       out  1              registered RF write enable
//  rf_waddr_o    out  5              registered RF write address
//  rf_wdata_o    out  XLEN           registered RF write data
//  pend_mask_o   out  32             bit r set while a write to xr is queued or in flight
//  fifo_count_o  out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset (rst_i=1 at a clock edge): all of the following go to 0 -- pointers, count,
//   starve counter, stall_o, rf_we_o, rf_waddr_o, rf_wdata_o. FIFO contents are discarded.
//   pend_mask_o=0 and lsu_ready_o=1 after reset. Mid-operation reset drops queued writes.
//  lsu_ready_o = (count < DEPTH). It depends on registered count only; a same-cycle pop
//   does not free a slot.
//  Push: lsu_valid_i & lsu_ready_o & (lsu_rd_i != 0).
//   A handshake with lsu_rd_i=0 completes but stores nothing.
//  Pop: (count > 0) & (stall_o | !alu_valid_i). Simultaneous push+pop leaves count unchanged.
//  Select each cycle, in priority order:
//   stall_o=1 -> FIFO head.
//   alu_valid_i -> ALU.
//   pop -> FIFO head.
//   none -> no write.
//  Output register: rf_we_o <= selected & (rd != 0); rf_waddr_o/rf_wdata_o load only when
//   rf_we_o is set, otherwise they hold. Latency is 1 cycle for the ALU and >= 2 cycles
//   for the LSU. There is no FIFO bypass.
//  ALU rd=0: rf_we_o=0 next cycle; the ALU still owns that cycle and the FIFO is not popped.
//  Starvation:
//   starve_cnt increments when count>0 & alu_valid_i & !stall_o.
//   starve_cnt clears to 0 on any pop or when count==0.
//   stall_o <= increment & (starve_cnt == STARVE_MAX-1), i.e. a one-cycle pulse; the
//   counter clears in the same cycle.
//   alu_valid_i=1 while stall_o=1 is a protocol violation: the ALU result is dropped and a
//   bench assertion fires.
//  pend_mask_o: OR of onehot(rd) over valid FIFO entries, OR onehot(rf_waddr_o) when
//   rf_we_o. Combinational from registers. Bit 0 is always 0.
//  Ordering: FIFO drain order is strict FIFO. WAW ordering against the ALU is the issuer's
//   responsibility, enforced via pend_mask_o.
// STRUCTURE
//  tcore_param: XLEN; add wb_entry_t packed struct {logic [4:0] rd; logic [XLEN-1:0] data;}
//   and typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_LSU} wb_src_e.
//  Sub-module wb_fifo: sync FIFO of wb_entry_t with push/pop/count, exposing its entry array
//   and per-entry valid bits for the mask.
//  Top level holds the select logic, starve counter and output register.
// TESTING
//  1 Reset 2 cycles -> rf_we_o=0, stall_o=0, lsu_ready_o=1, fifo_count_o=0, pend_mask_o=0.
//  2 ALU rd=5 data=0xDEADBEEF at t -> t+1: rf_we_o=1, rf_waddr_o=5, wdata=0xDEADBEEF.
//    ALU rd=0 -> rf_we_o=0.
//  3 ALU idle; LSU rd=7 data=0x1234 at t -> t+1: pend_mask_o=0x80, count=1.
//    t+2: RF write x7=0x1234. t+3: mask=0.
//  4 ALU busy; 5 LSU results rd=1..5 offered -> lsu_ready_o=0 after 4 pushes, 5th held.
//    ALU idle -> writes x1..x5 in order.
//  5 One queued entry with alu_valid_i held high 8 cycles (STARVE_MAX=8) -> stall_o high
//    exactly 1 cycle, entry written the cycle after, stall_o low again.
//  6 Three entries queued, rst_i pulsed 1 cycle -> count=0, mask=0, no RF write for the
//    dropped entries.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter.
//   XLEN       : integer datapath width
//   wb_entry_t : one pending register-file write (destination + data)
//   wb_src_e   : which source owns the RF write port in a given cycle
//   rd_onehot  : one-hot decode of a destination register index
package wb_arbiter_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_LSU
    } wb_src_e;

    function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending writeback entries.
// Exposes the raw entry array and per-entry valid bits so the parent can build
// a mask of destination registers that still have a write outstanding.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push       : store i_wdata (caller guarantees the FIFO is not full)
//   i_pop        : drop the head entry (caller guarantees the FIFO is not empty)
//   o_head       : oldest entry
//   o_count      : occupancy, 0..DEPTH
//   o_entries    : storage array, indexed by physical slot
//   o_valid      : slot holds a queued entry
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  wb_entry_t                   i_wdata,
    output wb_entry_t                   o_head,
    output logic [$clog2(DEPTH):0]      o_count,
    output wb_entry_t [DEPTH-1:0]       o_entries,
    output logic [DEPTH-1:0]            o_valid
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [PTR_W-1:0]      w_off;

    // Contents are not reset: a cleared count makes every slot invalid.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A slot is live when its distance from the read pointer is below the count.
    always_comb begin
        o_valid = '0;
        w_off   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_off      = PTR_W'(i) - r_rd_ptr;
            o_valid[i] = ({1'b0, w_off} < r_count);
        end
    end

    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_entries = r_mem;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter in front of the integer register file write port.
// The ALU (single cycle, never stalled) has priority; LSU/MUL-DIV results are
// queued and drain when the ALU is idle. If the ALU keeps the queue blocked for
// STARVE_MAX cycles, stall_o pulses for one cycle and the head entry is written.
//   clk_i, rst_i                  : clock, synchronous active-high reset
//   alu_valid_i/rd_i/data_i       : ALU result
//   lsu_valid_i/ready_o/rd_i/data_i : LSU result, valid/ready handshake
//   stall_o                       : upstream must hold alu_valid_i low this cycle
//   rf_we_o/waddr_o/wdata_o       : registered RF write port
//   pend_mask_o                   : registers with a queued or in-flight write
//   fifo_count_o                  : LSU queue occupancy
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     alu_valid_i,
    input  logic [4:0]               alu_rd_i,
    input  logic [XLEN-1:0]          alu_data_i,
    input  logic                     lsu_valid_i,
    output logic                     lsu_ready_o,
    input  logic [4:0]               lsu_rd_i,
    input  logic [XLEN-1:0]          lsu_data_i,
    output logic                     stall_o,
    output logic                     rf_we_o,
    output logic [4:0]               rf_waddr_o,
    output logic [XLEN-1:0]          rf_wdata_o,
    output logic [31:0]              pend_mask_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX);

    wb_entry_t             w_lsu_entry;
    wb_entry_t             w_head;
    wb_entry_t [DEPTH-1:0] w_entries;
    logic [DEPTH-1:0]      w_valid;
    logic [CNT_W-1:0]      w_count;
    logic                  w_nonempty;
    logic                  w_push;
    logic                  w_pop;
    wb_src_e               w_src;
    logic [4:0]            w_sel_rd;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_sel_we;
    logic                  w_inc;
    logic                  w_hit;
    logic [31:0]           w_mask;

    logic                  r_stall;
    logic [STARVE_W-1:0]   r_starve;
    logic                  r_we;
    logic [4:0]            r_waddr;
    logic [XLEN-1:0]       r_wdata;

    assign w_lsu_entry = '{rd: lsu_rd_i, data: lsu_data_i};
    assign w_nonempty  = (w_count != '0);
    assign lsu_ready_o = (w_count < CNT_W'(DEPTH));
    // rd=0 results are accepted but discarded.
    assign w_push      = lsu_valid_i & lsu_ready_o & (lsu_rd_i != 5'd0);
    assign w_pop       = w_nonempty & (r_stall | ~alu_valid_i);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wdata   (w_lsu_entry),
        .o_head    (w_head),
        .o_count   (w_count),
        .o_entries (w_entries),
        .o_valid   (w_valid)
    );

    // A pop only happens when stall_o forces it or the ALU is idle, so it
    // implies FIFO ownership. An ALU result presented during stall_o is dropped.
    always_comb begin
        w_src = WB_NONE;
        if (w_pop) begin
            w_src = WB_LSU;
        end else if (alu_valid_i && !r_stall) begin
            w_src = WB_ALU;
        end
    end

    always_comb begin
        w_sel_rd   = '0;
        w_sel_data = '0;
        case (w_src)
            WB_ALU: begin
                w_sel_rd   = alu_rd_i;
                w_sel_data = alu_data_i;
            end
            WB_LSU: begin
                w_sel_rd   = w_head.rd;
                w_sel_data = w_head.data;
            end
            default: ;
        endcase
        w_sel_we = (w_src != WB_NONE) && (w_sel_rd != 5'd0);
    end

    assign w_inc = w_nonempty & alu_valid_i & ~r_stall;
    assign w_hit = w_inc & (r_starve == STARVE_W'(STARVE_MAX - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            if (w_pop || !w_nonempty || w_hit) begin
                r_starve <= '0;
            end else if (w_inc) begin
                r_starve <= r_starve + 1'b1;
            end
            r_stall <= w_hit;
        end
    end

    // Address and data hold their last written value when no write occurs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_sel_we;
            if (w_sel_we) begin
                r_waddr <= w_sel_rd;
                r_wdata <= w_sel_data;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (w_valid[i]) begin
                w_mask = w_mask | rd_onehot(w_entries[i].rd);
            end
        end
        if (r_we) begin
            w_mask = w_mask | rd_onehot(r_waddr);
        end
    end

    assign pend_mask_o  = {w_mask[31:1], 1'b0};
    assign stall_o      = r_stall;
    assign rf_we_o      = r_we;
    assign rf_waddr_o   = r_waddr;
    assign rf_wdata_o   = r_wdata;
    assign fifo_count_o = w_count;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_wb_arbiter;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        alu_valid_i = 1'b0;
    logic [4:0]  alu_rd_i = '0;
    logic [31:0] alu_data_i = '0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i = '0;
    logic [31:0] lsu_data_i = '0;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] pend_mask_o;
    logic [2:0]  fifo_count_o;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .alu_valid_i  (alu_valid_i),
        .alu_rd_i     (alu_rd_i),
        .alu_data_i   (alu_data_i),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_rd_i     (lsu_rd_i),
        .lsu_data_i   (lsu_data_i),
        .stall_o      (stall_o),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .rf_wdata_o   (rf_wdata_o),
        .pend_mask_o  (pend_mask_o),
        .fifo_count_o (fifo_count_o)
    );

    // ALU valid during stall_o is an upstream protocol violation.
    always @(posedge clk) begin
        if (!rst_i && stall_o && alu_valid_i) begin
            n_cmp++;
            n_fail++;
            $display("FAIL protocol: alu_valid_i=1 while stall_o=1 at %0t", $time);
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_stall;
    int          m_starve;
    logic        m_pushed;

    function automatic void model_update();
        int   sz;
        logic ready, push, pop, inc, hit, sv;
        ent_t sel;
        m_pushed = 1'b0;
        if (rst_i) begin
            q.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_stall = 0; m_starve = 0;
            return;
        end
        sz    = q.size();
        ready = (sz < DEPTH);
        push  = lsu_valid_i && ready && (lsu_rd_i != 0);
        pop   = (sz > 0) && (m_stall || !alu_valid_i);
        sv    = 1'b0;
        sel   = '{rd: 5'd0, data: 32'd0};
        if (pop) begin
            sv  = 1'b1;
            sel = q[0];
        end else if (alu_valid_i && !m_stall) begin
            sv  = 1'b1;
            sel = '{rd: alu_rd_i, data: alu_data_i};
        end
        inc = (sz > 0) && alu_valid_i && !m_stall;
        hit = inc && (m_starve == STARVE_MAX - 1);
        if (pop || sz == 0 || hit) m_starve = 0;
        else if (inc) m_starve = m_starve + 1;
        m_we = sv && (sel.rd != 0);
        if (m_we) begin
            m_addr = sel.rd;
            m_data = sel.data;
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{rd: lsu_rd_i, data: lsu_data_i});
        m_pushed = push;
        m_stall  = hit;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_model();
        logic [31:0] em;
        em = '0;
        foreach (q[i]) em = em | (32'd1 << q[i].rd);
        if (m_we) em = em | (32'd1 << m_addr);
        em[0] = 1'b0;
        chk("m_we",    rf_we_o,      m_we);
        chk("m_waddr", rf_waddr_o,   m_addr);
        chk("m_wdata", rf_wdata_o,   m_data);
        chk("m_stall", stall_o,      m_stall);
        chk("m_ready", lsu_ready_o,  q.size() < DEPTH);
        chk("m_count", fifo_count_o, q.size());
        chk("m_mask",  pend_mask_o,  em);
    endfunction

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
        alu_valid_i = av; alu_rd_i = ard; alu_data_i = ad;
        lsu_valid_i = lv; lsu_rd_i = lrd; lsu_data_i = ld;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cnt;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          idx;
        int          got[$];
        logic        av;

        vecs[0] = '{1, 5,  32'hDEADBEEF, 0, 0,  0,     1, 5,  32'hDEADBEEF, 0, 32'h20};
        vecs[1] = '{1, 0,  32'h11,       0, 0,  0,     0, 5,  32'hDEADBEEF, 0, 32'h0};
        vecs[2] = '{0, 0,  0,            1, 7,  32'h1234, 0, 5, 32'hDEADBEEF, 1, 32'h80};
        vecs[3] = '{0, 0,  0,            0, 0,  0,     1, 7,  32'h1234,     0, 32'h80};
        vecs[4] = '{0, 0,  0,            0, 0,  0,     0, 7,  32'h1234,     0, 32'h0};
        vecs[5] = '{1, 3,  32'hA,        1, 0,  32'hB, 1, 3,  32'hA,        0, 32'h8};
        vecs[6] = '{1, 0,  32'h0,        1, 9,  32'hC, 0, 3,  32'hA,        1, 32'h200};
        vecs[7] = '{0, 0,  0,            1, 10, 32'hD, 1, 9,  32'hC,        1, 32'h600};
        vecs[8] = '{0, 0,  0,            0, 0,  0,     1, 10, 32'hD,        0, 32'h400};
        vecs[9] = '{0, 0,  0,            0, 0,  0,     0, 10, 32'hD,        0, 32'h0};

        // Reset state
        do_reset();
        chk("rst_we",    rf_we_o,      0);
        chk("rst_stall", stall_o,      0);
        chk("rst_ready", lsu_ready_o,  1);
        chk("rst_count", fifo_count_o, 0);
        chk("rst_mask",  pend_mask_o,  0);

        // ALU write, ALU rd=0, LSU single entry, rd=0 handshake, push+pop
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].ad, vecs[i].lv, vecs[i].lrd, vecs[i].ld);
            step();
            chk($sformatf("vec%0d_we", i),    rf_we_o,      vecs[i].we);
            chk($sformatf("vec%0d_addr", i),  rf_waddr_o,   vecs[i].addr);
            chk($sformatf("vec%0d_data", i),  rf_wdata_o,   vecs[i].data);
            chk($sformatf("vec%0d_count", i), fifo_count_o, vecs[i].cnt);
            chk($sformatf("vec%0d_mask", i),  pend_mask_o,  vecs[i].mask);
        end

        // Fill while ALU busy: fifth LSU result held until a slot frees
        do_reset();
        idx = 1;
        for (int c = 0; c < 6; c++) begin
            drive(1, 5'd20, c, idx <= 5, 5'(idx), 32'h100 + idx);
            step();
            if (m_pushed) idx++;
            if (c >= 3) begin
                chk("fill_count", fifo_count_o, 4);
                chk("fill_ready", lsu_ready_o,  0);
            end
        end
        for (int c = 0; c < 12; c++) begin
            drive(0, 0, 0, idx <= 5, 5'(idx), 32'h100 + idx);
            step();
            if (m_pushed) idx++;
            if (rf_we_o) got.push_back(int'(rf_waddr_o));
        end
        chk("drain_len", got.size(), 5);
        for (int i = 0; i < got.size() && i < 5; i++) chk("drain_order", got[i], i + 1);

        // Starvation guard
        do_reset();
        drive(1, 5'd2, 32'h55, 1, 5'd12, 32'hC0FFEE);
        step();
        chk("starve_count", fifo_count_o, 1);
        for (int c = 0; c < 8; c++) begin
            drive(1, 5'd2, c, 0, 0, 0);
            step();
            chk(c == 7 ? "starve_rise" : "starve_quiet", stall_o, c == 7);
        end
        drive(0, 0, 0, 0, 0, 0);
        step();
        chk("starve_fall",  stall_o,      0);
        chk("starve_we",    rf_we_o,      1);
        chk("starve_addr",  rf_waddr_o,   12);
        chk("starve_data",  rf_wdata_o,   32'hC0FFEE);
        chk("starve_empty", fifo_count_o, 0);

        // Mid-operation reset drops queued writes
        do_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1, 5'd0, 0, 1, 5'(13 + c), 32'h200 + c);
            step();
        end
        chk("mid_count_pre", fifo_count_o, 3);
        drive(0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("mid_count", fifo_count_o, 0);
        chk("mid_mask",  pend_mask_o,  0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("mid_no_write", rf_we_o, 0);
        end

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst_i = ($urandom_range(0, 299) == 0);
            av    = ($urandom_range(0, 99) < 70) && !m_stall;
            drive(av, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
